// File: rtl/if_fetch_queue_if.sv
// ----------------------------------------------------------------------------
// if_fetch_queue_if: push/pop/status bundle between fetch, queue and decode. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface if_fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             i_flush;
  logic             i_push_valid;
  logic             o_push_ready;
  logic [31:0]      i_push_pc;
  logic [31:0]      i_push_instr;
  logic             i_push_pred;
  logic             o_pop_valid;
  logic             i_pop_ready;
  logic [31:0]      o_pc;
  logic [31:0]      o_instr;
  logic             o_pred_taken;
  logic [CNT_W-1:0] o_count;
  logic             o_almost_full;

  // The queue itself sits on the slave side.
  modport slave (
    input  i_flush, i_push_valid, i_push_pc, i_push_instr, i_push_pred, i_pop_ready,
    output o_push_ready, o_pop_valid, o_pc, o_instr, o_pred_taken, o_count, o_almost_full
  );

  modport master (
    output i_flush, i_push_valid, i_push_pc, i_push_instr, i_push_pred, i_pop_ready,
    input  o_push_ready, o_pop_valid, o_pc, o_instr, o_pred_taken, o_count, o_almost_full
  );
endinterface

`default_nettype wire

// File: rtl/if_fetch_queue.sv
// ----------------------------------------------------------------------------
// if_fetch_queue: in-order {pc, instr, pred_taken} queue, fetch -> IF/ID. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module if_fetch_queue #(
  parameter int          DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  wire logic        i_clk,
  input  wire logic        i_reset,
  if_fetch_queue_if.slave  bus
);
  localparam int               PTR_W = $clog2(DEPTH);
  localparam int               CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

  logic [31:0]      pc_q    [DEPTH];
  logic [31:0]      instr_q [DEPTH];
  logic             pred_q  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic             not_empty;
  logic             push_fire;
  logic             pop_fire;

  // Flush suppresses both handshakes internally; push_ready still looks only at count.
  always_comb begin
    not_empty = (count_q != '0);
    push_fire = bus.i_push_valid & (count_q != FULL) & ~bus.i_flush;
    pop_fire  = bus.i_pop_ready & not_empty & ~bus.i_flush;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (bus.i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_fire) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_fire)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_fire) - CNT_W'(pop_fire);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an empty queue masks it on the head outputs.
  always_ff @(posedge i_clk) begin
    if (push_fire) begin
      pc_q[wr_ptr_q]    <= bus.i_push_pc;
      instr_q[wr_ptr_q] <= bus.i_push_instr;
      pred_q[wr_ptr_q]  <= bus.i_push_pred;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      assert (count_q <= FULL)
        else $error("if_fetch_queue: occupancy %0d above depth", count_q);
    end
  end

  assign bus.o_push_ready  = (count_q != FULL);
  assign bus.o_pop_valid   = not_empty;
  assign bus.o_count       = count_q;
  assign bus.o_almost_full = (count_q >= (FULL - CNT_W'(1)));
  assign bus.o_pc          = not_empty ? pc_q[rd_ptr_q]    : 32'h0;
  assign bus.o_instr       = not_empty ? instr_q[rd_ptr_q] : NOP;
  assign bus.o_pred_taken  = not_empty ? pred_q[rd_ptr_q]  : 1'b0;

endmodule

`default_nettype wire
